alu_181: RTL and testbench

- 74181-style ALU widened to WIDTH bits (default 16): 16 logic functions (mode=1) and 16 arithmetic functions (mode=0), selected by a 4-bit op code.
- Uses 74181 active-high-data conventions: carry_in and carry_out are active-low.
- Combinational datapath followed by an output register. Sits in a CPU datapath as the general-purpose ALU.

---
 rtl/alu_181_if.sv | 22 ++
 rtl/alu_181.sv | 106 ++++++++++
 tb/tb_alu_181.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/alu_181_if.sv
// Operand, function-select and result bus of the 74181-style ALU.
// No handshake: the ALU takes one operation on every rising edge and presents its result one cycle later.
interface alu_181_if #(parameter int WIDTH = 16);
  logic [WIDTH-1:0] A_in;
  logic [WIDTH-1:0] B_in;
  logic [3:0]       op_in;
  logic             mode;
  logic             carry_in;
  logic [WIDTH-1:0] out;
  logic             carry_out;
  logic             equal_out;

  modport master (
    output A_in, B_in, op_in, mode, carry_in,
    input  out, carry_out, equal_out
  );

  modport slave (
    input  A_in, B_in, op_in, mode, carry_in,
    output out, carry_out, equal_out
  );
endinterface

// File: rtl/alu_181.sv
// 74181-style ALU widened to WIDTH bits. It uses active-low carry in/out and a registered result.
// The adder is built from 4-bit lookahead slices, which are chained through slice-level group P/G terms.
module alu_181 #(
  parameter int WIDTH = 16
) (
  input  logic      clk,
  input  logic      rst,
  alu_181_if.slave  bus
);
  localparam int NSLICE = WIDTH / 4;

  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] f_comb;

  logic [WIDTH-1:0] out_d, out_q;
  logic             carry_out_d, carry_out_q;
  logic             equal_out_d, equal_out_q;

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      op1[i] = bus.A_in[i] | (bus.B_in[i] & bus.op_in[0]) | (~bus.B_in[i] & bus.op_in[1]);
      op2[i] = (bus.A_in[i] & ~bus.B_in[i] & bus.op_in[2]) |
               (bus.A_in[i] &  bus.B_in[i] & bus.op_in[3]);
    end
  end

  // Carry network. Bit generate is g = op1 & op2 and bit propagate is p = op1 | op2.
  // Each slice expands its own carries from its slice carry-in.
  always_comb begin
    logic [WIDTH-1:0]  g;
    logic [WIDTH-1:0]  p;
    logic [NSLICE-1:0] grp_g;
    logic [NSLICE-1:0] grp_p;
    logic [NSLICE:0]   slice_c;
    logic [3:0]        sg;
    logic [3:0]        sp;
    logic              c0;

    g       = op1 & op2;
    p       = op1 | op2;
    grp_g   = '0;
    grp_p   = '0;
    slice_c = '0;
    carry   = '0;
    sg      = '0;
    sp      = '0;
    c0      = 1'b0;

    for (int s = 0; s < NSLICE; s++) begin
      sg = g[s*4 +: 4];
      sp = p[s*4 +: 4];
      grp_g[s] = sg[3] | (sp[3] & sg[2]) | (sp[3] & sp[2] & sg[1]) |
                 (sp[3] & sp[2] & sp[1] & sg[0]);
      grp_p[s] = &sp;
    end

    slice_c[0] = ~bus.carry_in;
    for (int s = 0; s < NSLICE; s++) begin
      slice_c[s+1] = grp_g[s] | (grp_p[s] & slice_c[s]);
    end

    for (int s = 0; s < NSLICE; s++) begin
      sg = g[s*4 +: 4];
      sp = p[s*4 +: 4];
      c0 = slice_c[s];
      carry[s*4]     = c0;
      carry[s*4 + 1] = sg[0] | (sp[0] & c0);
      carry[s*4 + 2] = sg[1] | (sp[1] & sg[0]) | (sp[1] & sp[0] & c0);
      carry[s*4 + 3] = sg[2] | (sp[2] & sg[1]) | (sp[2] & sp[1] & sg[0]) |
                       (sp[2] & sp[1] & sp[0] & c0);
    end
    carry[WIDTH] = slice_c[NSLICE];
  end

  // In logic mode the carry path still runs. Only F switches source, as on the 74181.
  always_comb begin
    if (bus.mode) begin
      f_comb = ~(op1 ^ op2);
    end else begin
      f_comb = (op1 ^ op2) ^ carry[WIDTH-1:0];
    end
  end

  always_comb begin
    out_d       = f_comb;
    carry_out_d = ~carry[WIDTH];
    equal_out_d = &f_comb;
    if (rst) begin
      out_d       = '0;
      carry_out_d = 1'b1;
      equal_out_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    out_q       <= out_d;
    carry_out_q <= carry_out_d;
    equal_out_q <= equal_out_d;
  end

  assign bus.out       = out_q;
  assign bus.carry_out = carry_out_q;
  assign bus.equal_out = equal_out_q;
endmodule

// File: tb/tb_alu_181.sv
// Directed bench for alu_181. It drives inputs on the falling edge and checks the registered results 1 time unit after the rising edge.
module tb_alu_181;
  localparam int W = 16;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  alu_181_if #(.WIDTH(W)) bus ();

  alu_181 #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent reference model: plain wide ripple add of op1 + op2 + carry.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [3:0] s, input logic m, input logic cin);
    logic [W-1:0] o1, o2, f;
    logic [W:0]   sum;
    o1  = a | (b & {W{s[0]}}) | (~b & {W{s[1]}});
    o2  = (a & ~b & {W{s[2]}}) | (a & b & {W{s[3]}});
    sum = {1'b0, o1} + {1'b0, o2} + {{W{1'b0}}, ~cin};
    f   = m ? ~(o1 ^ o2) : sum[W-1:0];
    return {~sum[W], &f, f};
  endfunction

  task automatic step(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] s,
                      input logic m, input logic cin, input logic r);
    @(negedge clk);
    bus.A_in     = a;
    bus.B_in     = b;
    bus.op_in    = s;
    bus.mode     = m;
    bus.carry_in = cin;
    rst          = r;
    @(posedge clk);
    #1;
  endtask

  task automatic check_f(input string tag, input logic [W-1:0] exp_f, input logic exp_eq);
    checks++;
    assert (bus.out === exp_f) else begin
      errors++;
      $error("FAIL %s out: got %h expected %h", tag, bus.out, exp_f);
    end
    checks++;
    assert (bus.equal_out === exp_eq) else begin
      errors++;
      $error("FAIL %s equal_out: got %b expected %b", tag, bus.equal_out, exp_eq);
    end
  endtask

  task automatic check(input string tag, input logic [W-1:0] exp_f, input logic exp_c,
                       input logic exp_eq);
    check_f(tag, exp_f, exp_eq);
    checks++;
    assert (bus.carry_out === exp_c) else begin
      errors++;
      $error("FAIL %s carry_out: got %b expected %b", tag, bus.carry_out, exp_c);
    end
  endtask

  initial begin
    logic [W+1:0] exp;
    logic [W-1:0] ra, rb;
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    bus.A_in = '0; bus.B_in = '0; bus.op_in = '0; bus.mode = 1'b0; bus.carry_in = 1'b1;

    // Reset state
    step(16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b1, 1'b1);
    check("reset", 16'h0000, 1'b1, 1'b0);

    // A+B, then step A with B held
    step(16'h0000, 16'h0001, 4'b1001, 1'b0, 1'b1, 1'b0);
    check("add_0_1", 16'h0001, 1'b1, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      step(W'(i), 16'h0001, 4'b1001, 1'b0, 1'b1, 1'b0);
      check("add_stream", W'(i + 1), 1'b1, 1'b0);
    end

    // Wrap with and without carry-in
    step(16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b1, 1'b0);
    check("add_wrap", 16'h0000, 1'b0, 1'b0);
    step(16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b0, 1'b0);
    check("add_wrap_cin", 16'h0001, 1'b0, 1'b0);

    // Subtract / compare
    step(16'h0005, 16'h0005, 4'b0110, 1'b0, 1'b0, 1'b0);
    check("sub_eq", 16'h0000, 1'b0, 1'b0);
    step(16'h0005, 16'h0005, 4'b0110, 1'b0, 1'b1, 1'b0);
    check("cmp_eq", 16'hFFFF, 1'b1, 1'b1);
    step(16'h0007, 16'h0003, 4'b0110, 1'b0, 1'b0, 1'b0);
    check("sub_7_3", 16'h0004, 1'b0, 1'b0);
    step(16'h0000, 16'h0000, 4'b0011, 1'b0, 1'b1, 1'b0);
    check("minus1", 16'hFFFF, 1'b1, 1'b1);
    step(16'h8000, 16'h1234, 4'b1100, 1'b0, 1'b1, 1'b0);
    check("a_plus_a", 16'h0000, 1'b0, 1'b0);

    // Logic functions, both carry-in values
    for (int c = 0; c < 2; c++) begin
      step(16'hF0F0, 16'hFF00, 4'b0110, 1'b1, c[0], 1'b0);
      check_f("xor", 16'h0FF0, 1'b0);
      step(16'hF0F0, 16'hFF00, 4'b1011, 1'b1, c[0], 1'b0);
      check_f("and", 16'hF000, 1'b0);
      step(16'hF0F0, 16'hFF00, 4'b0000, 1'b1, c[0], 1'b0);
      check_f("not_a", 16'h0F0F, 1'b0);
      step(16'hF0F0, 16'hFF00, 4'b1100, 1'b1, c[0], 1'b0);
      check_f("ones", 16'hFFFF, 1'b1);
      step(16'hF0F0, 16'hFF00, 4'b1110, 1'b1, c[0], 1'b0);
      check_f("or", 16'hFFF0, 1'b0);
      step(16'hF0F0, 16'hFF00, 4'b0011, 1'b1, c[0], 1'b0);
      check_f("zero", 16'h0000, 1'b0);
    end

    // Full sweep of mode, select and carry-in against the model
    for (int m = 0; m < 2; m++) begin
      for (int s = 0; s < 16; s++) begin
        for (int c = 0; c < 2; c++) begin
          ra  = W'($urandom_range(0, 65535));
          rb  = W'($urandom_range(0, 65535));
          exp = model(ra, rb, s[3:0], m[0], c[0]);
          step(ra, rb, s[3:0], m[0], c[0], 1'b0);
          check("sweep", exp[W-1:0], exp[W+1], exp[W]);
        end
      end
    end

    // Reset in the middle of a stream of operations, then release
    step(16'h1111, 16'h2222, 4'b1001, 1'b0, 1'b1, 1'b0);
    check("pre_rst", 16'h3333, 1'b1, 1'b0);
    step(16'hFFFF, 16'hFFFF, 4'b1001, 1'b0, 1'b0, 1'b1);
    check("mid_rst", 16'h0000, 1'b1, 1'b0);
    step(16'h0005, 16'h0005, 4'b0110, 1'b0, 1'b1, 1'b1);
    check("hold_rst", 16'h0000, 1'b1, 1'b0);
    step(16'h0005, 16'h0005, 4'b0110, 1'b0, 1'b1, 1'b0);
    check("post_rst", 16'hFFFF, 1'b1, 1'b1);
    step(16'hFFFF, 16'hFFFF, 4'b1001, 1'b0, 1'b0, 1'b0);
    check("post_rst2", 16'hFFFF, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
